// File: rtl/mem_responder.sv
// mem_responder: single-outstanding valid/ready memory responder with programmable wait states
// and a one-cycle response pulse.
module mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state, state_nxt;
   logic [3:0] cnt;
   logic we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic in_range, do_access;
   // Out-of-range addresses never alias onto implemented words
   assign in_range = {1'b0, addr_q} < (ADDR_W+1)'(DEPTH);
   always_comb begin
      req_ready = state == IDLE && !reset;
      busy      = state != IDLE && !reset;
      rsp_valid = state == RESP;
      do_access = state == ACCESS && cnt == 4'd0;
      state_nxt = state == IDLE ? (req_valid ? ACCESS : IDLE) :
                  state == ACCESS ? (cnt == 4'd0 ? RESP : ACCESS) : IDLE;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (req_ready && req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= 4'(WAIT_CYCLES);
         end else if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
         if (do_access) begin
            rsp_rdata <= !in_range ? '0 : we_q ? wdata_q : mem[addr_q[IW-1:0]];
            rsp_err   <= !in_range;
         end
      end
   end
   // Storage is deliberately left out of reset
   always_ff @(posedge clock)
      if (!reset && do_access && we_q && in_range) mem[addr_q[IW-1:0]] <= wdata_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (wait states 2, 0, 15; 200 words) each driven by its own
// stimulus thread and checked by a scoreboard monitor against an associative-array memory model.
module tb_mem_responder;
   typedef struct {
      logic [15:0] d;
      bit          known;
      bit          err;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : inst
      localparam int W = g == 0 ? 2 : g == 1 ? 0 : 15;
      logic        reset = 1'b1;
      logic        req_valid = 1'b0;
      logic        req_we = 1'b0;
      logic [7:0]  req_addr = 8'h00;
      logic [15:0] req_wdata = 16'h0000;
      logic        req_ready, rsp_valid, rsp_err, busy;
      logic [15:0] rsp_rdata;
      logic [15:0] model [int];
      exp_t        q[$];
      int          last_acc = 0;
      int          prev_acc = 0;
      bit          fin = 1'b0;

      mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(200), .WAIT_CYCLES(W)) dut (
         .clock(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
         .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
         .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
      );

      task automatic c(input string n, input logic [31:0] act, input logic [31:0] exp);
         chk($sformatf("W=%0d %s", W, n), act, exp);
      endtask

      always @(negedge clk) begin
         exp_t e;
         if (!reset) begin
            if (rsp_valid) begin
               if (q.size() == 0) c("spurious rsp_valid", rsp_valid, 1'b0);
               else begin
                  e = q.pop_front();
                  c("rsp cycle", cyc, e.due);
                  c("rsp_err", rsp_err, e.err);
                  if (e.known) c("rsp_rdata", rsp_rdata, e.d);
               end
            end else if (q.size() > 0 && cyc >= q[0].due) begin
               c("missing rsp_valid", rsp_valid, 1'b1);
               void'(q.pop_front());
            end
         end
      end

      task automatic issue(input bit we, input logic [7:0] a, input logic [15:0] d,
                           input bit keep, input bit expect_rsp);
         exp_t e;
         int acc;
         req_we = we;
         req_addr = a;
         req_wdata = d;
         req_valid = 1'b1;
         #1;
         for (int i = 0; i < 100 && !req_ready; i++) begin
            @(negedge clk);
            #1;
         end
         if (!req_ready) begin
            c("accept timeout", req_ready, 1'b1);
            req_valid = 1'b0;
            return;
         end
         acc = cyc + 1;
         e.due = acc + W + 1;
         e.err = a >= 8'd200;
         e.known = 1'b1;
         e.d = 16'h0000;
         if (!e.err) begin
            if (we) e.d = d;
            else if (model.exists(int'(a))) e.d = model[int'(a)];
            else e.known = 1'b0;
         end
         if (expect_rsp) begin
            q.push_back(e);
            if (we && !e.err) model[int'(a)] = d;
         end
         prev_acc = last_acc;
         last_acc = acc;
         @(negedge clk);
         if (!keep) req_valid = 1'b0;
      endtask

      task automatic wait_idle();
         int n = 0;
         #1;
         for (int i = 0; i < 40 && !req_ready; i++) begin
            n++;
            @(negedge clk);
            #1;
         end
         c("req_ready low cycles", n, W + 2);
      endtask

      initial begin
         req_valid = 1'b1;
         req_we = 1'b1;
         req_addr = 8'h03;
         req_wdata = 16'hBEEF;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            c("reset req_ready", req_ready, 1'b0);
            c("reset rsp_valid", rsp_valid, 1'b0);
            c("reset rsp_rdata", rsp_rdata, 16'h0000);
            c("reset rsp_err", rsp_err, 1'b0);
         end
         reset = 1'b0;
         req_valid = 1'b0;
         #1;
         c("ready after reset", req_ready, 1'b1);
         c("no accept in reset", busy, 1'b0);
         @(negedge clk);
         issue(1'b1, 8'h05, 16'h1234, 1'b0, 1'b1);
         wait_idle();
         issue(1'b0, 8'h05, 16'h0000, 1'b0, 1'b1);
         wait_idle();
         issue(1'b1, 8'h01, 16'hAAAA, 1'b1, 1'b1);
         issue(1'b0, 8'h01, 16'h0000, 1'b0, 1'b1);
         c("back-to-back spacing", last_acc - prev_acc, W + 3);
         wait_idle();
         issue(1'b1, 8'h00, 16'h5A5A, 1'b0, 1'b1);
         wait_idle();
         issue(1'b1, 8'hC8, 16'hFFFF, 1'b0, 1'b1);
         wait_idle();
         issue(1'b0, 8'hC8, 16'h0000, 1'b0, 1'b1);
         wait_idle();
         issue(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
         wait_idle();
         issue(1'b1, 8'hFF, 16'h7777, 1'b0, 1'b1);
         wait_idle();
         issue(1'b1, 8'h10, 16'h1111, 1'b0, 1'b1);
         wait_idle();
         issue(1'b1, 8'h10, 16'h2222, 1'b0, 1'b0);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         #1;
         c("abandoned write busy", busy, 1'b0);
         issue(1'b0, 8'h10, 16'h0000, 1'b0, 1'b1);
         wait_idle();
         for (int k = 0; k < 40; k++) begin
            int r = int'($urandom_range(0, 3));
            logic [7:0] a = r == 0 ? 8'($urandom_range(200, 255)) :
                            r == 1 ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 199));
            issue(1'($urandom_range(0, 1)), a, 16'($urandom), 1'b0, 1'b1);
            if ($urandom_range(0, 1) == 1) wait_idle();
         end
         for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
         c("scoreboard drained", q.size(), 0);
         fin = 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 50000 && !(inst[0].fin && inst[1].fin && inst[2].fin); i++) @(posedge clk);
      chk("all threads finished", {inst[0].fin, inst[1].fin, inst[2].fin}, 3'b111);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
